fb_swap_ctrl: RTL and testbench
===============================

FB_SWAP_CTRL -- requirements
Module: fb_swap_ctrl

Interface
REQ-001 SHALL have parameter HOR_ACTIVE_PIXELS, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter VER_ACTIVE_PIXELS, default 480, meaning active lines per frame; derived AW = $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS), N = HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ce  input  1  clock enable for all state, counter and memory-write updates.
REQ-006 SHALL have port wr_en  input  1  renderer pixel write strobe.
REQ-007 SHALL have port wr_addr  input  AW  renderer pixel address (y*HOR_ACTIVE_PIXELS+x).
REQ-008 SHALL have port wr_data  input  1  renderer pixel value.
REQ-009 SHALL have port render_done  input  1  one-cycle pulse: renderer finished current frame.
REQ-010 SHALL have port vblank  input  1  level from video timing, high during vertical blanking.
REQ-011 SHALL have port rd_en  input  1  display read strobe.
REQ-012 SHALL have port rd_addr  input  AW  display pixel address.
REQ-013 SHALL have port rd_data  output  1  registered front-bank pixel.
REQ-014 SHALL have port swap  output  1  one-cycle pulse to renderer: back bank cleared, start new frame.
REQ-015 SHALL have port front_sel  output  1  bank currently displayed (0 or 1).
REQ-016 SHALL have port missed  output  8  saturating count of vblank edges with no finished frame.

Function
REQ-017 SHALL contain two 1-bit x N banks; back bank = ~front_sel.
REQ-018 SHALL implement states CLEAR, RENDER, WAIT_VBLANK, FLIP; all transitions only when ce=1.
REQ-019 CLEAR: write 0 to back bank at clear counter 0..N-1, one address per ce cycle; after address N-1 SHALL go to RENDER and pulse swap for exactly that one ce cycle.
REQ-020 RENDER: write wr_data to back[wr_addr] when wr_en=1 and wr_addr<N; wr_addr>=N SHALL be ignored.
REQ-021 RENDER + render_done=1 SHALL go to WAIT_VBLANK; a write in that same cycle SHALL still be accepted.
REQ-022 vblank rising edge (registered previous value, sampled under ce) SHALL be detected as vb_rise.
REQ-023 WAIT_VBLANK + vb_rise SHALL go to FLIP; writes in WAIT_VBLANK SHALL be ignored.
REQ-024 RENDER + render_done + vb_rise in the same cycle SHALL go directly to FLIP with no miss counted.
REQ-025 RENDER + vb_rise without render_done SHALL increment missed (saturate at 255) and remain in RENDER; front_sel unchanged.
REQ-026 FLIP (one cycle): toggle front_sel, set front_valid=1, reset clear counter, go to CLEAR.
REQ-027 render_done outside RENDER SHALL be ignored; wr_en outside RENDER SHALL be ignored.
REQ-028 rd_data SHALL equal front[rd_addr] one cycle after rd_en=1, using front_sel of the request cycle; SHALL hold when rd_en=0; SHALL be 0 when front_valid=0 or rd_addr>=N.
REQ-029 Reads SHALL not depend on ce.

Reset
REQ-030 On rst=0: state=CLEAR, clear counter=0, front_sel=0, front_valid=0, swap=0, rd_data=0, missed=0, vblank history=0; bank contents undefined.
REQ-031 Reset asserted mid-CLEAR or mid-RENDER SHALL abandon the frame; after release the sequence restarts with a full CLEAR of bank 1 and a single swap pulse.

Verification (HOR=8, VER=4, N=32, ce=1)
REQ-032 Release reset -> swap pulses exactly once, 32 cycles after release; front_sel=0; rd_data=0 for all addresses.
REQ-033 Write 1 to addr 5 and 31, render_done, vblank rise -> front_sel=1 after FLIP; reads of 5 and 31 return 1 one cycle after rd_en; others 0.
REQ-034 Two vblank rises without render_done -> missed=2, front_sel unchanged; render_done+vb_rise same cycle -> FLIP, missed stays 2.
REQ-035 wr_en with wr_addr=40 in RENDER, and wr_en during WAIT_VBLANK/CLEAR -> no bank change; after flip, previous-front bank cleared to all 0 before next swap.
REQ-036 ce held low for 10 cycles mid-CLEAR -> swap delayed exactly 10 cycles; rd_data still updates on rd_en.
REQ-037 rst=0 mid-RENDER -> all outputs at reset values asynchronously; REQ-032 sequence repeats after release.

Source files
------------

// File: rtl/fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// fb_swap_ctrl -- double-buffered 1-bit framebuffer with vblank-synchronous flip
//
// Two 1-bit x N banks. The display reads the front bank, and the renderer writes
// the back bank (back = ~front_sel). Each frame is handled in four steps:
// CLEAR the back bank, pulse swap, accept renderer writes until render_done,
// then wait for a vblank rising edge and FLIP. A vblank rise that arrives while
// the renderer is still busy is counted in a saturating 'missed' counter.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : asynchronous active-low reset
//   ce          : clock enable for FSM, counters and bank writes (not reads)
//   wr_en       : renderer write strobe (honoured only while rendering)
//   wr_addr     : renderer pixel address y*HOR+x, values >= N are ignored
//   wr_data     : renderer pixel value
//   render_done : one-cycle pulse, renderer finished the frame
//   vblank      : vertical blanking level from video timing
//   rd_en       : display read strobe
//   rd_addr     : display pixel address
//   rd_data     : front-bank pixel, valid one cycle after rd_en, held otherwise
//   swap        : one-cycle pulse, back bank cleared and renderer may start
//   front_sel   : bank currently displayed
//   missed      : saturating count of vblank rises with no finished frame
// -----------------------------------------------------------------------------
module fb_swap_ctrl #(
   parameter  int HOR_ACTIVE_PIXELS = 640,
   parameter  int VER_ACTIVE_PIXELS = 480,
   localparam int N  = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
   localparam int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic          wr_data,
   input  logic          render_done,
   input  logic          vblank,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_data,
   output logic          swap,
   output logic          front_sel,
   output logic [7:0]    missed
);

   localparam logic [AW:0]   N_EXT     = (AW+1)'(N);
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

   typedef enum logic [1:0] {
      S_CLEAR,
      S_RENDER,
      S_WAIT_VBLANK,
      S_FLIP
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_clr_cnt;
   logic          r_front_sel;
   logic          r_front_valid;
   logic          r_swap;
   logic          r_vb_prev;
   logic [7:0]    r_missed;
   logic          r_rd_ok;
   logic          r_rd_sel;

   logic          w_vb_rise;
   logic          w_back;
   logic          w_wr_in_range;
   logic          w_rd_in_range;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic          w_wdata;

   assign w_vb_rise     = vblank & ~r_vb_prev;
   assign w_back        = ~r_front_sel;
   assign w_wr_in_range = ({1'b0, wr_addr} < N_EXT);
   assign w_rd_in_range = ({1'b0, rd_addr} < N_EXT);

   // Single back-bank write port shared by the clear sweep and the renderer.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_clr_cnt;
      w_wdata = 1'b0;
      if (ce) begin
         if (r_state == S_CLEAR) begin
            w_we = 1'b1;
         end else if (r_state == S_RENDER && wr_en && w_wr_in_range) begin
            w_we    = 1'b1;
            w_waddr = wr_addr;
            w_wdata = wr_data;
         end
      end
   end

   // Frame sequencing FSM with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_CLEAR;
         r_clr_cnt     <= '0;
         r_front_sel   <= 1'b0;
         r_front_valid <= 1'b0;
         r_swap        <= 1'b0;
         r_vb_prev     <= 1'b0;
         r_missed      <= 8'd0;
      end else begin
         // swap is a single-clock pulse; it is only ever raised below
         r_swap <= 1'b0;
         if (ce) begin
            r_vb_prev <= vblank;
            case (r_state)
               S_CLEAR: begin
                  if (r_clr_cnt == LAST_ADDR) begin
                     r_state <= S_RENDER;
                     r_swap  <= 1'b1;
                  end else begin
                     r_clr_cnt <= r_clr_cnt + 1'b1;
                  end
               end
               S_RENDER: begin
                  if (render_done) begin
                     // a frame finished exactly on the vblank edge flips at once
                     r_state <= w_vb_rise ? S_FLIP : S_WAIT_VBLANK;
                  end else if (w_vb_rise && r_missed != 8'hFF) begin
                     r_missed <= r_missed + 8'd1;
                  end
               end
               S_WAIT_VBLANK: begin
                  if (w_vb_rise) begin
                     r_state <= S_FLIP;
                  end
               end
               S_FLIP: begin
                  r_front_sel   <= ~r_front_sel;
                  r_front_valid <= 1'b1;
                  r_clr_cnt     <= '0;
                  r_state       <= S_CLEAR;
               end
               default: r_state <= S_CLEAR;
            endcase
         end
      end
   end

   // Read-side qualifiers: the bank and validity are latched with the request
   // so that a flip in the same cycle does not change the returned pixel.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_ok  <= 1'b0;
         r_rd_sel <= 1'b0;
      end else if (rd_en) begin
         r_rd_ok  <= r_front_valid & w_rd_in_range;
         r_rd_sel <= r_front_sel;
      end
   end

   // Bank storage: plain arrays with a registered read each, no reset on
   // contents so they map onto block RAM.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         logic r_mem [0:N-1];
         logic r_q;
         always_ff @(posedge clk) begin
            if (w_we && (w_back == 1'(gi))) begin
               r_mem[w_waddr] <= w_wdata;
            end
            if (rd_en && w_rd_in_range) begin
               r_q <= r_mem[rd_addr];
            end
         end
      end
   endgenerate

   assign rd_data   = r_rd_ok & (r_rd_sel ? g_bank[1].r_q : g_bank[0].r_q);
   assign swap      = r_swap;
   assign front_sel = r_front_sel;
   assign missed    = r_missed;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_ctrl -- self-checking bench for fb_swap_ctrl (HOR=8, VER=4, N=32)
// A frame-level reference model (two bit arrays, a remaining-clear count and
// done/flip flags) is advanced once per clock, and every output is compared
// after each edge. Directed steps are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_fb_swap_ctrl;

   localparam int HOR = 8;
   localparam int VER = 4;
   localparam int N   = HOR * VER;
   localparam int AW  = $clog2(N);

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic          wr_data;
   logic          render_done;
   logic          vblank;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_data;
   logic          swap;
   logic          front_sel;
   logic [7:0]    missed;

   always #5 clk = ~clk;

   fb_swap_ctrl #(
      .HOR_ACTIVE_PIXELS(HOR),
      .VER_ACTIVE_PIXELS(VER)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce         (ce),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .render_done(render_done),
      .vblank     (vblank),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .swap       (swap),
      .front_sel  (front_sel),
      .missed     (missed)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit mb [2][N];
   bit m_front, m_valid, m_vb_prev, m_swap, m_rd, m_done, m_flip;
   int m_clear_left;
   int m_missed;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_front      = 1'b0;
      m_valid      = 1'b0;
      m_vb_prev    = 1'b0;
      m_swap       = 1'b0;
      m_rd         = 1'b0;
      m_done       = 1'b0;
      m_flip       = 1'b0;
      m_clear_left = N;
      m_missed     = 0;
   endfunction

   // One clock of the frame-level behaviour, applied with the inputs present at the edge.
   function automatic void model_step();
      bit vb_rise;
      if (rst !== 1'b1) begin
         model_reset();
         return;
      end
      m_swap = 1'b0;
      if (rd_en) m_rd = (m_valid && int'(rd_addr) < N) ? mb[m_front][rd_addr] : 1'b0;
      if (!ce) return;
      vb_rise   = vblank && !m_vb_prev;
      m_vb_prev = vblank;
      if (m_flip) begin
         m_front      = !m_front;
         m_valid      = 1'b1;
         m_flip       = 1'b0;
         m_done       = 1'b0;
         m_clear_left = N;
      end else if (m_clear_left > 0) begin
         mb[!m_front][N - m_clear_left] = 1'b0;
         m_clear_left--;
         if (m_clear_left == 0) m_swap = 1'b1;
      end else if (!m_done) begin
         if (wr_en && int'(wr_addr) < N) mb[!m_front][wr_addr] = wr_data;
         if (render_done) begin
            m_done = 1'b1;
            m_flip = vb_rise;
         end else if (vb_rise && m_missed < 255) begin
            m_missed++;
         end
      end else if (vb_rise) begin
         m_flip = 1'b1;
      end
   endfunction

   task automatic check_all();
      chk("swap",      swap,      m_swap);
      chk("front_sel", front_sel, m_front);
      chk("missed",    missed,    m_missed);
      chk("rd_data",   rd_data,   m_rd);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   // Runs until swap is seen (random reads on the way); n = edges taken.
   task automatic wait_swap(output int n);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         rd_en   = 1'b1;
         rd_addr = AW'($urandom_range(0, N - 1));
         cycle();
         n++;
         if (swap === 1'b1) break;
      end
      rd_en = 1'b0;
   endtask

   int n;
   int rd_list [6] = '{0, 4, 5, 6, 30, 31};

   initial begin
      rst = 1'b1; ce = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 1'b0;
      render_done = 1'b0; vblank = 1'b0; rd_en = 1'b0; rd_addr = '0;
      model_reset();

      // reset values
      #2 rst = 1'b0;
      #1;
      chk("rst_swap", swap, 1'b0);
      chk("rst_front", front_sel, 1'b0);
      chk("rst_missed", missed, 8'd0);
      chk("rst_rd", rd_data, 1'b0);
      cycle();
      cycle();
      rst = 1'b1;

      // first clear: swap exactly 32 edges after release, reads all 0
      wait_swap(n);
      chk("swap_after_release", n, 32);
      chk("front_init", front_sel, 1'b0);

      // render two pixels, finish, flip on vblank rise
      wr_en = 1'b1; wr_data = 1'b1; wr_addr = AW'(5);
      cycle();
      wr_addr = AW'(31);
      cycle();
      wr_en = 1'b0; render_done = 1'b1;
      cycle();
      render_done = 1'b0; vblank = 1'b1;
      cycle();
      cycle();
      chk("front_after_flip", front_sel, 1'b1);
      vblank = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1; rd_addr = AW'(rd_list[i]);
         cycle();
         chk("rd_bank1", rd_data, (rd_list[i] == 5 || rd_list[i] == 31));
      end
      rd_en = 1'b0; rd_addr = '0;
      cycle();
      chk("rd_hold", rd_data, 1'b1);

      // two vblank rises while still rendering
      wait_swap(n);
      chk("swap_after_flip", n, 32 - 7);
      for (int i = 0; i < 2; i++) begin
         vblank = 1'b1; cycle();
         vblank = 1'b0; cycle();
      end
      chk("missed_two", missed, 8'd2);
      chk("front_no_flip", front_sel, 1'b1);

      // render_done coinciding with vblank rise flips with no extra miss
      render_done = 1'b1; vblank = 1'b1;
      cycle();
      render_done = 1'b0;
      cycle();
      chk("front_direct_flip", front_sel, 1'b0);
      chk("missed_kept", missed, 8'd2);
      vblank = 1'b0;

      // writes during CLEAR ignored; ce low 10 cycles stalls the sweep
      wr_en = 1'b1; wr_data = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_addr = AW'($urandom_range(0, N - 1));
         cycle();
      end
      ce = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rd_en = 1'b1; rd_addr = AW'($urandom_range(0, N - 1));
         cycle();
      end
      ce = 1'b1;
      wait_swap(n);
      wr_en = 1'b0;
      chk("swap_ce_stall", 15 + n, 42);

      // writes during WAIT_VBLANK ignored; old front bank was cleared
      render_done = 1'b1;
      cycle();
      render_done = 1'b0; wr_en = 1'b1; wr_addr = AW'(7);
      cycle();
      wr_en = 1'b0; vblank = 1'b1;
      cycle();
      cycle();
      chk("front_second_flip", front_sel, 1'b1);
      vblank = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1; rd_addr = AW'(rd_list[i]);
         cycle();
         chk("rd_cleared", rd_data, 1'b0);
      end
      rd_en = 1'b1; rd_addr = AW'(7);
      cycle();
      chk("rd_wait_write_ignored", rd_data, 1'b0);
      rd_en = 1'b0;

      // asynchronous reset in the middle of RENDER
      wait_swap(n);
      wr_en = 1'b1; wr_addr = AW'(3);
      cycle();
      wr_en = 1'b0;
      #3 rst = 1'b0;
      #1;
      model_reset();
      chk("async_swap", swap, 1'b0);
      chk("async_front", front_sel, 1'b0);
      chk("async_missed", missed, 8'd0);
      chk("async_rd", rd_data, 1'b0);
      cycle();
      cycle();
      rst = 1'b1;
      wait_swap(n);
      chk("swap_after_rerelease", n, 32);

      // randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         ce          = ($urandom_range(0, 7) != 0);
         wr_en       = $urandom_range(0, 1) == 1;
         wr_addr     = AW'($urandom_range(0, N - 1));
         wr_data     = $urandom_range(0, 1) == 1;
         render_done = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) vblank = ~vblank;
         rd_en       = $urandom_range(0, 1) == 1;
         rd_addr     = AW'($urandom_range(0, N - 1));
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
